rate_divider_multi: RTL
=======================

Name: rate_divider_multi

Overview:
Multi-channel programmable tick generator for the 50 MHz game clock domain. It provides NUM_CH independent down-counters, each emitting a one-cycle enable pulse every (period+1) clocks. Each channel runs in periodic or one-shot mode and is reprogrammed at runtime through a single write port. Animation, movement-step and debounce logic consume the tick outputs as clock enables.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 26, counter/period width in bits
SEL_W, 2, width of channel select; 2**SEL_W >= NUM_CH required
DEFAULT_PERIOD, 49999999, period loaded into every channel at reset (1 Hz at 50 MHz); must fit in CNT_W

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ch_enable  input  NUM_CH  per-channel run enable; low = channel frozen
wr_en  input  1  write strobe for channel configuration
wr_ch  input  SEL_W  channel addressed by write
wr_period  input  CNT_W  new period value P
wr_oneshot  input  1  new mode: 1 = one-shot, 0 = periodic
tick  output  NUM_CH  registered one-cycle enable pulse per channel
done  output  NUM_CH  one-shot completion flag per channel (sticky)

Behaviour:
- Per channel state: period_r[CNT_W], count_r[CNT_W], oneshot_r, done_r, tick_r. All updates occur on the rising edge of clock.
- Reset (reset=1 on an edge) overrides everything:
  - period_r=DEFAULT_PERIOD, count_r=DEFAULT_PERIOD, oneshot_r=0.
  - tick=0, done=0.
- Channel enabled (ch_enable[i]=1) and not done:
  - count_r==0: tick_r<=1, count_r<=period_r, and in one-shot mode done_r<=1.
  - Otherwise: tick_r<=0, count_r<=count_r-1.
- Tick spacing: ticks occur every P+1 cycles. With enable held high from the first post-reset edge, the first tick is visible after edge P+1.
- P=0: tick is held high every cycle (full-speed pass-through).
- Channel disabled: count_r holds and tick_r<=0. Re-enabling resumes from the held count; no restart.
- One-shot done: count_r is parked at period_r, tick stays 0, and done stays 1 until the channel is rewritten or reset.
- Write (wr_en=1, wr_ch<NUM_CH) to channel i:
  - period_r<=wr_period, oneshot_r<=wr_oneshot.
  - If count_r > wr_period, count_r<=wr_period (immediate clamp; no overlong wait).
  - If wr_oneshot=1 or done_r=1: count_r<=wr_period and done_r<=0 (re-arm).
- Write with wr_ch>=NUM_CH: ignored, no state change.
- Write and count_r==0 on the same edge, same channel: the tick still fires, the reload uses wr_period (forwarded), and the mode uses wr_oneshot.
- Write while the channel is disabled: the register update still occurs; tick stays 0.
- Channels are fully independent; a write to channel i never affects any channel j≠i.
- No counter wraps: decrement only occurs from nonzero.

Optional Feature:
- Macro RATE_DIV_SYNC_EN.
- When defined: adds input port sync (1 bit, after wr_oneshot). On an edge with sync=1 and reset=0, every channel sets count_r<=period_r, tick_r<=0, done_r<=0. A same-cycle write to channel i uses wr_period for that channel's load. Sync overrides the enable/count logic but not the write register update.
- When undefined: no sync port; behaviour exactly as above.

Test Plan:
- Reset, then write ch0 P=3 periodic, enable ch0 -> tick[0] high exactly one cycle in every 4; other ticks remain 0 with ch_enable low.
- Write ch1 P=0, enable -> tick[1] high continuously every cycle; write P=2 -> pattern becomes 1-in-3 within 3 cycles.
- Ch2 running P=1000 at count 800, write P=5 -> count clamps to 5 and a tick appears 6 cycles later, then every 6.
- Ch3 one-shot P=4, enable -> a single tick at edge 5 and done[3]=1; no further ticks over 50 cycles; rewrite P=2 one-shot -> done clears and one tick occurs 3 cycles later.
- Ch0 P=3: drop ch_enable for 10 cycles mid-count -> tick 0 throughout and the count resumes with the remaining interval; assert reset mid-run -> next edge tick=0, done=0, count=DEFAULT_PERIOD.
- With RATE_DIV_SYNC_EN: ch0 P=3 and ch1 P=7 at arbitrary phases, pulse sync -> both restart, and the first ticks come 4 and 8 cycles after the sync edge.

Source files
------------

// File: rtl/rate_divider_multi.sv
// Multi-channel programmable tick generator: NUM_CH independent down-counters, each pulsing tick every (period+1) clocks.
// Latency: tick/done are registered; a tick becomes visible on the edge after its counter has reached zero.
// Backpressure: none; ch_enable freezes a channel and the write port is accepted on every cycle.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   ch_enable       per-channel run enable (low = counter frozen, tick forced low)
//   wr_en/wr_ch     configuration write strobe and target channel (wr_ch >= NUM_CH is ignored)
//   wr_period       new period P (tick spacing P+1)
//   wr_oneshot      new mode: 1 = one-shot, 0 = periodic
//   sync            (only with RATE_DIV_SYNC_EN) restarts every channel from its period
//   tick            one-cycle enable pulse per channel
//   done            sticky one-shot completion flag per channel
//
// Optional feature macro: RATE_DIV_SYNC_EN adds the sync input.

module rate_divider_multi #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 26,
    parameter int          SEL_W          = 2,
    parameter int unsigned DEFAULT_PERIOD = 49999999
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0]  wr_period,
    input  logic              wr_oneshot,
`ifdef RATE_DIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    // Per-channel state.
    logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
    logic [NUM_CH-1:0][CNT_W-1:0] count_q,  count_d;
    logic [NUM_CH-1:0]            oneshot_q, oneshot_d;
    logic [NUM_CH-1:0]            done_q,   done_d;
    logic [NUM_CH-1:0]            tick_q,   tick_d;

    // Per-channel decode helpers.
    logic [NUM_CH-1:0]            wr_hit;    // this channel is addressed by the write port
    logic [NUM_CH-1:0]            run;       // counting this cycle
    logic [NUM_CH-1:0]            fire;      // counting and at zero: tick fires this edge
    logic [NUM_CH-1:0][CNT_W-1:0] load_val;  // reload value, forwarded from a same-cycle write
    logic [NUM_CH-1:0]            mode_val;  // one-shot mode, forwarded from a same-cycle write
    logic                         sync_w;

`ifdef RATE_DIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        // Addresses >= NUM_CH never match any instantiated channel, so those writes drop out.
        assign wr_hit[g]   = wr_en && (wr_ch == SEL_W'(g));
        assign run[g]      = ch_enable[g] && !done_q[g];
        assign fire[g]     = run[g] && (count_q[g] == '0);
        assign load_val[g] = wr_hit[g] ? wr_period  : period_q[g];
        assign mode_val[g] = wr_hit[g] ? wr_oneshot : oneshot_q[g];
    end

    always_comb begin
        period_d  = period_q;
        count_d   = count_q;
        oneshot_d = oneshot_q;
        done_d    = done_q;
        tick_d    = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            // Counter / tick path. Sync restarts the channel and takes priority over counting.
            if (sync_w) begin
                count_d[i] = load_val[i];
                done_d[i]  = 1'b0;
            end else if (fire[i]) begin
                tick_d[i]  = 1'b1;
                count_d[i] = load_val[i];
                done_d[i]  = mode_val[i];
            end else if (run[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end

            // Configuration write. Registers always update; the count adjustment is skipped
            // when the reload above already used the forwarded write values.
            if (wr_hit[i]) begin
                period_d[i]  = wr_period;
                oneshot_d[i] = wr_oneshot;
                if (!sync_w && !fire[i]) begin
                    if (wr_oneshot || done_q[i]) begin
                        // Re-arm: start a fresh interval from the new period.
                        count_d[i] = wr_period;
                        done_d[i]  = 1'b0;
                    end else if (count_q[i] > wr_period) begin
                        // Shortened period: clamp so the channel never waits out the old interval.
                        count_d[i] = wr_period;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_q  <= {NUM_CH{DEF_P}};
            count_q   <= {NUM_CH{DEF_P}};
            oneshot_q <= '0;
            done_q    <= '0;
            tick_q    <= '0;
        end else begin
            period_q  <= period_d;
            count_q   <= count_d;
            oneshot_q <= oneshot_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;
    assign done = done_q;

endmodule
